// File: rtl/block_memory_responder_pkg.sv
// Shared definitions for the line-granular data memory responder.
// Holds the FSM state encoding, default geometry/latency and the counter width.
package dmem_pkg;

  localparam int DEF_BLOCK_SIZE = 16;
  localparam int DEF_DELAY      = 50;
  localparam int CNT_W          = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/block_memory_responder_line_ram.sv
// Line storage: DEPTH lines of WIDTH bits, synchronous write, combinational read.
// Deliberately has no reset so contents survive a responder reset.
module line_ram #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/block_memory_responder.sv
// Data memory responder: accepts one line read/write, waits DELAY cycles, completes it.
// Optional sticky protocol_err output is built when DMEM_PROTOCOL_CHECK_EN is defined.
// Handshake: a request is taken at a rising edge when is_input_valid & mem_ready &
// (mem_read | mem_write); is_output_valid is a one-cycle pulse that qualifies dout.
module block_memory_responder
  import dmem_pkg::*;
#(
  parameter int BLOCK_SIZE = DEF_BLOCK_SIZE,
  parameter int DELAY      = DEF_DELAY,
  parameter int NUM_LINES  = 256
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    is_input_valid,
  input  logic [31:0]             addr,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [8*BLOCK_SIZE-1:0] din,
  output logic                    is_output_valid,
  output logic [8*BLOCK_SIZE-1:0] dout,
  output logic                    mem_ready,
`ifdef DMEM_PROTOCOL_CHECK_EN
  output logic                    protocol_err,
`endif
  output logic [1:0]              dbg_state
);

  localparam int W     = 8 * BLOCK_SIZE;
  localparam int OFF   = $clog2(BLOCK_SIZE);
  localparam int IDX_W = $clog2(NUM_LINES);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               rd_q, rd_d;
  logic               wr_q, wr_d;
  logic [W-1:0]       din_q, din_d;
  logic [W-1:0]       dout_q, dout_d;
  logic [W-1:0]       ram_rdata;
  logic               accept;
  logic               done;
  logic               unused_addr;

  assign unused_addr = ^addr;
  assign accept = (state_q == ST_IDLE) && is_input_valid && (mem_read || mem_write);
  assign done   = (state_q == ST_WAIT) && (cnt_q == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      din_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      din_q   <= din_d;
      dout_q  <= dout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_WAIT;
      ST_WAIT: if (done) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Request latches and counter; write wins when both qualifiers are set.
  always_comb begin
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    rd_d   = rd_q;
    wr_d   = wr_q;
    din_d  = din_q;
    dout_d = dout_q;
    if (accept) begin
      idx_d = addr[OFF +: IDX_W];
      wr_d  = mem_write;
      rd_d  = mem_read && !mem_write;
      din_d = din;
      cnt_d = CNT_W'(DELAY - 1);
    end
    if (state_q == ST_WAIT && cnt_q != '0) cnt_d = cnt_q - 1'b1;
    if (done && rd_q) dout_d = ram_rdata;
  end

  always_comb begin
    mem_ready       = (state_q == ST_IDLE);
    is_output_valid = (state_q == ST_RESP) && rd_q;
    dout            = dout_q;
    dbg_state       = state_q;
  end

  line_ram #(
    .WIDTH (W),
    .DEPTH (NUM_LINES)
  ) u_ram (
    .clk   (clk),
    .we    (done && wr_q),
    .waddr (idx_q),
    .wdata (din_q),
    .raddr (idx_q),
    .rdata (ram_rdata)
  );

`ifdef DMEM_PROTOCOL_CHECK_EN
  logic perr_q, perr_d;

  always_comb begin
    perr_d = perr_q
           || (is_input_valid && !mem_ready)
           || (accept && mem_read && mem_write);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) perr_q <= 1'b0;
    else        perr_q <= perr_d;
  end

  assign protocol_err = perr_q;
`endif

endmodule

// File: tb/tb_block_memory_responder.sv
// Bench for block_memory_responder: one instance at DELAY=50 and one at DELAY=1,
// random line traffic checked against an array model through an expected-data queue.
module tb_block_memory_responder;

  localparam int W     = 128;
  localparam int LINES = 16;
  localparam int D0    = 50;
  localparam int D1    = 1;
  localparam logic [W-1:0] PAT  = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [W-1:0] AAAA = {8{16'hAAAA}};

  logic         clk;
  logic         rst_n [2];
  logic         t_iv [2];
  logic [31:0]  t_addr [2];
  logic         t_rd [2];
  logic         t_wr [2];
  logic [W-1:0] t_din [2];
  logic         t_ov [2];
  logic [W-1:0] t_dout [2];
  logic         t_rdy [2];
  logic [1:0]   t_st [2];
`ifdef DMEM_PROTOCOL_CHECK_EN
  logic         t_perr [2];
`endif

  int cmp_cnt = 0;
  int err_cnt = 0;

  logic [W-1:0] model [2][LINES];
  logic [W-1:0] last_read [2];
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];

  block_memory_responder #(.BLOCK_SIZE(16), .DELAY(D0), .NUM_LINES(LINES)) dut0 (
    .clk(clk), .reset(rst_n[0]), .is_input_valid(t_iv[0]), .addr(t_addr[0]),
    .mem_read(t_rd[0]), .mem_write(t_wr[0]), .din(t_din[0]),
    .is_output_valid(t_ov[0]), .dout(t_dout[0]), .mem_ready(t_rdy[0]),
`ifdef DMEM_PROTOCOL_CHECK_EN
    .protocol_err(t_perr[0]),
`endif
    .dbg_state(t_st[0])
  );

  block_memory_responder #(.BLOCK_SIZE(16), .DELAY(D1), .NUM_LINES(LINES)) dut1 (
    .clk(clk), .reset(rst_n[1]), .is_input_valid(t_iv[1]), .addr(t_addr[1]),
    .mem_read(t_rd[1]), .mem_write(t_wr[1]), .din(t_din[1]),
    .is_output_valid(t_ov[1]), .dout(t_dout[1]), .mem_ready(t_rdy[1]),
`ifdef DMEM_PROTOCOL_CHECK_EN
    .protocol_err(t_perr[1]),
`endif
    .dbg_state(t_st[1])
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int dly(input int k);
    return (k == 0) ? D0 : D1;
  endfunction

  function automatic logic [W-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Monitor: every output-valid pulse pops one expected line.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst_n[k] === 1'b1 && t_ov[k] === 1'b1) begin
        if (k == 0) begin
          if (exp_q0.size() == 0) chk("unexpected_valid0", 1, 0);
          else chk("rd_data0", t_dout[0], exp_q0.pop_front());
        end else begin
          if (exp_q1.size() == 0) chk("unexpected_valid1", 1, 0);
          else chk("rd_data1", t_dout[1], exp_q1.pop_front());
        end
      end
    end
  end

  // Driver tasks
  task automatic wait_ready(input int k);
    int n = 0;
    while (t_rdy[k] !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("ready_timeout", 0, 1);
  endtask

  task automatic start_op(input int k, input bit rd, input bit wr,
                          input logic [31:0] a, input logic [W-1:0] d);
    wait_ready(k);
    t_iv[k] = 1'b1; t_rd[k] = rd; t_wr[k] = wr; t_addr[k] = a; t_din[k] = d;
    @(posedge clk);
    @(negedge clk);
    t_iv[k] = 1'b0; t_rd[k] = 1'b0; t_wr[k] = 1'b0;
  endtask

  task automatic do_op(input int k, input bit rd, input bit wr,
                       input logic [31:0] a, input logic [W-1:0] d, input int inject_at);
    int idx = int'((a >> 4) % LINES);
    int nlow = 0;
    int npulse = 0;
    int pulse_j = 0;
    int j = 1;
    bit want_pulse = rd && !wr;
    if (!rd && !wr) begin
      wait_ready(k);
      t_iv[k] = 1'b1; t_addr[k] = a; t_din[k] = d;
      @(posedge clk);
      @(negedge clk);
      t_iv[k] = 1'b0;
      chk("ignored_ready", W'(t_rdy[k]), 1);
      chk("ignored_no_valid", W'(t_ov[k]), 0);
      return;
    end
    if (wr) model[k][idx] = d;
    else begin
      if (k == 0) exp_q0.push_back(model[k][idx]);
      else exp_q1.push_back(model[k][idx]);
      last_read[k] = model[k][idx];
    end
    start_op(k, rd, wr, a, d);
    chk("wait_state", W'(t_st[k]), 1);
    while (j < 300) begin
      if (t_rdy[k] !== 1'b1) nlow++;
      if (t_ov[k] === 1'b1) begin npulse++; pulse_j = j; end
      if (t_rdy[k] === 1'b1) break;
      if (inject_at != 0 && j == inject_at) begin
        t_iv[k] = 1'b1; t_rd[k] = 1'b1; t_wr[k] = 1'($urandom_range(0, 1));
        t_addr[k] = $urandom; t_din[k] = rnd_line();
      end else begin
        t_iv[k] = 1'b0; t_rd[k] = 1'b0; t_wr[k] = 1'b0;
      end
      @(negedge clk);
      j++;
    end
    t_iv[k] = 1'b0; t_rd[k] = 1'b0; t_wr[k] = 1'b0;
    if (j >= 300) chk("op_timeout", 0, 1);
    chk("busy_cycles", W'(nlow), W'(dly(k) + 1));
    chk("pulse_count", W'(npulse), want_pulse ? 1 : 0);
    if (want_pulse) chk("pulse_time", W'(pulse_j), W'(dly(k) + 1));
    chk("dout_hold", t_dout[k], last_read[k]);
  endtask

  task automatic check_reset_vals(input int k);
    chk("rst_ready", W'(t_rdy[k]), 1);
    chk("rst_valid", W'(t_ov[k]), 0);
    chk("rst_dout", t_dout[k], 0);
    chk("rst_state", W'(t_st[k]), 0);
`ifdef DMEM_PROTOCOL_CHECK_EN
    chk("rst_perr", W'(t_perr[k]), 0);
`endif
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0; t_iv[k] = 1'b0; t_rd[k] = 1'b0; t_wr[k] = 1'b0;
      t_addr[k] = '0; t_din[k] = '0; last_read[k] = '0;
    end
    repeat (3) @(negedge clk);
    check_reset_vals(0);
    check_reset_vals(1);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    @(negedge clk);

    // Give every line a known value.
    for (int i = 0; i < LINES; i++) begin
      do_op(0, 0, 1, 32'(i * 16), rnd_line(), 0);
      do_op(1, 0, 1, 32'(i * 16), rnd_line(), 0);
    end

    // Directed sequence at DELAY=50.
    do_op(0, 0, 1, 32'h40, PAT, 0);
    do_op(0, 1, 0, 32'h40, '0, 0);
    do_op(0, 1, 0, 32'h40 + LINES * 16, '0, 0);
    do_op(0, 0, 0, 32'h50, rnd_line(), 0);
`ifdef DMEM_PROTOCOL_CHECK_EN
    chk("perr_clean", W'(t_perr[0]), 0);
`endif
    do_op(0, 1, 0, 32'h80, '0, 10);
`ifdef DMEM_PROTOCOL_CHECK_EN
    chk("perr_busy_req", W'(t_perr[0]), 1);
`endif

    // Reset dropped in the middle of a write to line 7.
    do_op(0, 0, 1, 32'h70, AAAA, 0);
    start_op(0, 0, 1, 32'h70, rnd_line());
    repeat (19) @(negedge clk);
    rst_n[0] = 1'b0;
    #1;
    check_reset_vals(0);
    repeat (2) @(negedge clk);
    rst_n[0] = 1'b1;
    last_read[0] = '0;
    @(negedge clk);
    do_op(0, 1, 0, 32'h70, '0, 0);

    // Random traffic at DELAY=50.
    for (int n = 0; n < 20; n++) begin
      do_op(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, rnd_line(),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, D0 + 1)) : 0);
    end

    // DELAY=1: back-to-back reads, then random mix.
    for (int n = 0; n < 8; n++) do_op(1, 1, 0, 32'($urandom_range(0, 255)), '0, 0);
    for (int n = 0; n < 200; n++) begin
      do_op(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, rnd_line(),
            ($urandom_range(0, 7) == 0) ? 1 : 0);
    end
    do_op(1, 1, 1, 32'h30, rnd_line(), 0);
`ifdef DMEM_PROTOCOL_CHECK_EN
    chk("perr_both", W'(t_perr[1]), 1);
`endif
    do_op(1, 1, 0, 32'h30, '0, 0);

    repeat (3) @(negedge clk);
    chk("queue0_drained", W'(exp_q0.size()), 0);
    chk("queue1_drained", W'(exp_q1.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
